alu_sweep_ctrl: RTL and testbench
=================================

# alu_sweep_ctrl

Sequential driver and result collector for the 1-bit lab ALU. On a start request it steps the ALU's control and operand inputs through all 32 combinations of {A[1], A[0], S0, S1, M} and holds each vector for a programmable settle time. It samples the ALU's `result` for every vector and packs the samples into a 32-bit truth-table word. A valid/ready handshake hands that word to a downstream consumer such as a display or checker.

## Interface
- `SETTLE`, default 1: cycles each vector is held before its result is sampled; legal range 1..15.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle or level request to begin a sweep.
- `result` input 1: ALU output for the currently driven vector.
- `out_ready` input 1: consumer accepts `truth_table`.
- `M`, `S1`, `S0` output 1 each: ALU mode and select drive.
- `A` output 2: ALU operand drive.
- `busy` output 1: sweep in progress.
- `table_valid` output 1: `truth_table` is complete and offered.
- `truth_table` output 32: bit i is the ALU result for vector index i.

## Operation
- Vector index i (5 bits) maps to the drive lines as follows: M=i[0], S1=i[1], S0=i[2], A[0]=i[3], A[1]=i[4].
- FSM states:
  - IDLE: drives all 0; busy=0, table_valid=0. `start`=1 → DRIVE with idx=0, settle count=0, truth_table cleared to 0.
  - DRIVE: drives vector idx; busy=1. Settle count increments each cycle. When count==SETTLE-1, truth_table[idx] ← result and count ← 0. If idx==31 → DONE, else idx ← idx+1.
  - DONE: drives all 0; table_valid=1; truth_table is stable. `out_ready`=1 → IDLE.
- `start` is ignored in DRIVE and DONE; there is no queuing.
- truth_table keeps its last value in IDLE and is cleared only when the next sweep is accepted.
- Reset, including mid-sweep, immediately clears the following, and the block enters IDLE:
  - state → IDLE;
  - idx, count → 0;
  - truth_table → 0;
  - all outputs → 0.
- All outputs are registered; no combinational path runs from `result` or `out_ready` to any output.

## Timing
- Reset values: M=S1=S0=0, A=0, busy=0, table_valid=0, truth_table=0.
- With start sampled high at edge 0, vector 0 appears after edge 0 and busy rises with it.
- Each vector is held exactly SETTLE cycles. The sample for vector i is taken at edge (i+1)·SETTLE.
- The last sample is taken at edge 32·SETTLE. table_valid rises after that same edge; busy falls after it.
- Handshake: the transfer occurs at the edge where table_valid=1 and out_ready=1. table_valid falls after that edge.
  - table_valid, once high, holds until the transfer with truth_table unchanged.
  - If out_ready is already high, DONE lasts exactly 1 cycle.
- Earliest restart: start is accepted on the first IDLE cycle after the transfer edge.

## Structure
- Package `alu_sweep_pkg` contains:
  - state enum {IDLE, DRIVE, DONE};
  - constants NUM_VECTORS=32 and IDX_W=5;
  - the settle-counter width constant CNT_W=4.
- Sub-module `alu_sweep_counter`: holds the idx/settle counter pair and provides `last_settle` and `last_vec` flags. The FSM, sample register and output registers stay in `alu_sweep_ctrl`.
- In the top-level bench, this block's M/S1/S0/A outputs drive the ALU directly, and the ALU's result feeds back into `result`.

## Test plan
- Stub with result=M, SETTLE=1, out_ready=1, start pulsed once:
  - truth_table=32'hAAAA_AAAA;
  - table_valid high exactly 1 cycle, after edge 32.
- Result tied to 1, SETTLE=3: table_valid rises after edge 96 with truth_table=32'hFFFF_FFFF. Each vector's drive lines are checked against i over its 3-cycle window.
- Real ALU in loop, out_ready held low 10 cycles after completion:
  - table_valid and truth_table stay stable;
  - start pulses during that window cause no restart;
  - transfer happens on the out_ready edge.
- Start pulsed repeatedly at idx=5 during a sweep: the sweep is unaffected and completes at the nominal edge.
- rst_n asserted asynchronously mid-cycle at idx=10:
  - all outputs go to 0 without waiting for a clock edge;
  - after release, a new start produces the full correct table.
- Back-to-back sweeps:
  - start held high continuously with result=A[1] gives truth_table=32'hFFFF_0000;
  - the second sweep starts on the first IDLE cycle after the transfer.

Source files
------------

// File: rtl/alu_sweep_pkg.sv
// Shared types and constants for the ALU truth-table sweep controller.
package alu_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NUM_VECTORS = 32;
    localparam int IDX_W       = 5;
    localparam int CNT_W       = 4;

    // Drive lines presented to the ALU for one vector.
    typedef struct packed {
        logic       m;
        logic       s1;
        logic       s0;
        logic [1:0] a;
    } drive_t;

    // Vector index bit order: M is the LSB, A[1] the MSB.
    function automatic drive_t vec_to_drive(input logic [IDX_W-1:0] idx);
        drive_t d;
        d.m  = idx[0];
        d.s1 = idx[1];
        d.s0 = idx[2];
        d.a  = {idx[4], idx[3]};
        return d;
    endfunction

endpackage

// File: rtl/alu_sweep_if.sv
// ALU drive/feedback lines plus the start request and result handshake.
interface alu_sweep_if;

    logic        start;
    logic        result;
    logic        out_ready;
    logic        M;
    logic        S1;
    logic        S0;
    logic [1:0]  A;
    logic        busy;
    logic        table_valid;
    logic [31:0] truth_table;

    modport master (
        input  start, result, out_ready,
        output M, S1, S0, A, busy, table_valid, truth_table
    );

    modport slave (
        output start, result, out_ready,
        input  M, S1, S0, A, busy, table_valid, truth_table
    );

endinterface

// File: rtl/alu_sweep_counter.sv
// Vector index and settle counter pair; idx_next is exposed so the
// controller can register its drive lines one cycle ahead.
module alu_sweep_counter
    import alu_sweep_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             run,
    output logic [IDX_W-1:0] idx,
    output logic [IDX_W-1:0] idx_next,
    output logic             last_settle,
    output logic             last_vec
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    assign last_settle = (cnt == LAST_CNT);
    assign last_vec    = (idx == LAST_IDX);

    // Next counter values: clear on sweep start, advance index on the final settle cycle.
    always_comb begin
        idx_next = idx;
        cnt_next = cnt;
        if (clear) begin
            idx_next = '0;
            cnt_next = '0;
        end else if (run) begin
            if (last_settle) begin
                cnt_next = '0;
                idx_next = idx + IDX_W'(1);
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            cnt <= '0;
        end else begin
            idx <= idx_next;
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/alu_sweep_ctrl.sv
// Steps the 1-bit ALU through all 32 {A, S0, S1, M} vectors, samples its
// result after SETTLE cycles per vector and offers the packed truth table
// on a valid/ready handshake. SETTLE must lie in 1..15.
module alu_sweep_ctrl
    import alu_sweep_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_sweep_if.master  bus
);

    state_t           state;
    state_t           state_d;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic             last_settle;
    logic             last_vec;
    logic             accept;
    logic             run;

    drive_t           drive_d;
    logic             busy_d;
    logic             valid_d;

    drive_t           drive_q;
    logic             busy_q;
    logic             valid_q;
    logic [31:0]      table_q;

    assign accept = (state == IDLE) && bus.start;
    assign run    = (state == DRIVE);

    alu_sweep_counter #(.SETTLE(SETTLE)) u_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (accept),
        .run         (run),
        .idx         (idx),
        .idx_next    (idx_next),
        .last_settle (last_settle),
        .last_vec    (last_vec)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (bus.start) state_d = DRIVE;
            DRIVE:   if (last_settle && last_vec) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output values for the coming state, so every output is a plain flop.
    always_comb begin
        drive_d = '0;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        case (state_d)
            DRIVE: begin
                drive_d = vec_to_drive(idx_next);
                busy_d  = 1'b1;
            end
            DONE:    valid_d = 1'b1;
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drive_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            drive_q <= drive_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    // Sample register: cleared when a sweep is accepted, kept through IDLE otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            table_q <= '0;
        end else if (accept) begin
            table_q <= '0;
        end else if (run && last_settle) begin
            table_q[idx] <= bus.result;
        end
    end

    assign bus.M           = drive_q.m;
    assign bus.S1          = drive_q.s1;
    assign bus.S0          = drive_q.s0;
    assign bus.A           = drive_q.a;
    assign bus.busy        = busy_q;
    assign bus.table_valid = valid_q;
    assign bus.truth_table = table_q;

endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// Scoreboard bench for alu_sweep_ctrl: one SETTLE=3 instance with a
// selectable result source and a SETTLE=1 instance with result tied to M.
module tb_alu_sweep_ctrl;

    localparam int MODE_ONE = 0;
    localparam int MODE_ALU = 1;
    localparam int MODE_A1  = 2;
    localparam int MODE_LUT = 3;
    localparam int ST_A     = 3;
    localparam int SWEEP_A  = 32 * ST_A;

    typedef struct {
        logic [31:0] tbl;
        int          start_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   mode = MODE_ONE;
    logic [31:0] lut = '0;
    exp_t sb[$];
    logic hs_a = 1'b0;
    logic prev_valid = 1'b0;
    logic [31:0] held = '0;

    always #5 clk = ~clk;

    alu_sweep_if ifa();
    alu_sweep_if ifb();

    alu_sweep_ctrl #(.SETTLE(ST_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.master));
    alu_sweep_ctrl #(.SETTLE(1))    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.master));

    // Bench-defined lab ALU: logic ops when M=1, arithmetic bits when M=0.
    function automatic logic alu_ref(input logic m, input logic s1, input logic s0,
                                     input logic a1, input logic a0);
        case ({m, s1, s0})
            3'b100:  return a0 & a1;
            3'b101:  return a0 | a1;
            3'b110:  return a0 ^ a1;
            3'b111:  return ~a0;
            3'b000:  return a0;
            3'b001:  return a0 ^ a1;
            3'b010:  return ~a1;
            default: return a0 & a1;
        endcase
    endfunction

    function automatic logic stim_result(input int md, input logic [31:0] lt, input logic m,
                                         input logic s1, input logic s0, input logic [1:0] a);
        case (md)
            MODE_ONE: return 1'b1;
            MODE_ALU: return alu_ref(m, s1, s0, a[1], a[0]);
            MODE_A1:  return a[1];
            default:  return lt[{a[1], a[0], s0, s1, m}];
        endcase
    endfunction

    // Expected table from the index definition: bit i holds the result for vector i.
    function automatic logic [31:0] exp_table(input int md, input logic [31:0] lt);
        logic [31:0] t;
        logic [4:0]  v;
        t = '0;
        for (int i = 0; i < 32; i++) begin
            v = i[4:0];
            case (md)
                MODE_ONE: t[i] = 1'b1;
                MODE_ALU: t[i] = alu_ref(v[0], v[1], v[2], v[4], v[3]);
                MODE_A1:  t[i] = v[4];
                default:  t[i] = lt[i];
            endcase
        end
        return t;
    endfunction

    assign ifa.result = stim_result(mode, lut, ifa.M, ifa.S1, ifa.S0, ifa.A);
    assign ifb.result = ifb.M;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic to_cyc(input int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic start_a(input int md, output int e);
        mode = md;
        if (md == MODE_LUT) lut = $urandom;
        ifa.start = 1'b1;
        e = cyc + 1;
        sb.push_back('{tbl: exp_table(md, lut), start_cyc: e});
        @(negedge clk);
        ifa.start = 1'b0;
    endtask

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        hs_a <= rst_n && ifa.table_valid && ifa.out_ready;
    end

    // Monitor for dut_a: vector/busy windows, completion timing, handshake behaviour.
    always @(negedge clk) begin
        logic        rose;
        logic        expected_rise;
        logic [4:0]  lines;
        exp_t        e;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            rose          = ifa.table_valid && !prev_valid;
            expected_rise = 1'b0;
            lines         = {ifa.A, ifa.S0, ifa.S1, ifa.M};
            if (hs_a) begin
                check("valid_fall_after_xfer", {31'd0, ifa.table_valid}, 32'd0);
            end else if (prev_valid) begin
                check("valid_hold", {31'd0, ifa.table_valid}, 32'd1);
                check("table_stable", ifa.truth_table, held);
            end
            if (sb.size() > 0) begin
                e = sb[0];
                if (cyc >= e.start_cyc && cyc < e.start_cyc + SWEEP_A) begin
                    check("busy_in_sweep", {31'd0, ifa.busy}, 32'd1);
                    check("drive_vector", {27'd0, lines}, (cyc - e.start_cyc) / ST_A);
                end else if (cyc == e.start_cyc + SWEEP_A) begin
                    expected_rise = 1'b1;
                    check("valid_rise", {31'd0, ifa.table_valid}, 32'd1);
                    check("busy_fall", {31'd0, ifa.busy}, 32'd0);
                    check("truth_table", ifa.truth_table, e.tbl);
                    void'(sb.pop_front());
                end
            end
            if (rose && !expected_rise) check("unexpected_valid", 32'd1, 32'd0);
            prev_valid = ifa.table_valid;
            held       = ifa.truth_table;
        end
    end

    initial begin
        int ea;
        int eb;
        int e1;
        int d;
        ifa.start = 1'b0;
        ifa.out_ready = 1'b0;
        ifb.start = 1'b0;
        ifb.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        check("rst_drive_a", {27'd0, ifa.A, ifa.S0, ifa.S1, ifa.M}, 32'd0);
        check("rst_flags_a", {30'd0, ifa.busy, ifa.table_valid}, 32'd0);
        check("rst_table_a", ifa.truth_table, 32'd0);
        check("rst_drive_b", {27'd0, ifb.A, ifb.S0, ifb.S1, ifb.M}, 32'd0);
        check("rst_flags_b", {30'd0, ifb.busy, ifb.table_valid}, 32'd0);
        to_cyc(2);
        rst_n = 1'b1;
        @(negedge clk);

        // SETTLE=1, result=M, out_ready high, single start pulse.
        ifb.start = 1'b1;
        eb = cyc + 1;
        @(negedge clk);
        ifb.start = 1'b0;
        check("b_busy_rise", {31'd0, ifb.busy}, 32'd1);
        to_cyc(eb + 31);
        check("b_valid_early", {31'd0, ifb.table_valid}, 32'd0);
        to_cyc(eb + 32);
        check("b_valid_rise", {31'd0, ifb.table_valid}, 32'd1);
        check("b_table", ifb.truth_table, 32'hAAAA_AAAA);
        to_cyc(eb + 33);
        check("b_valid_one_cycle", {31'd0, ifb.table_valid}, 32'd0);

        // Result tied high, consumer always ready.
        ifa.out_ready = 1'b1;
        start_a(MODE_ONE, ea);
        to_cyc(ea + SWEEP_A + 2);

        // Real ALU, consumer stalls 10 cycles, start pulses in DONE ignored.
        ifa.out_ready = 1'b0;
        start_a(MODE_ALU, ea);
        to_cyc(ea + SWEEP_A);
        for (int k = 1; k <= 9; k++) begin
            to_cyc(ea + SWEEP_A + k);
            ifa.start = (k % 2 == 1);
        end
        to_cyc(ea + SWEEP_A + 10);
        ifa.start = 1'b0;
        ifa.out_ready = 1'b1;
        to_cyc(ea + SWEEP_A + 14);
        check("no_restart_after_stall", {31'd0, ifa.busy}, 32'd0);
        check("sb_drained", sb.size(), 32'd0);

        // Start pulses while idx=5 must not disturb the sweep.
        start_a(MODE_LUT, ea);
        to_cyc(ea + 5 * ST_A);
        ifa.start = 1'b1;
        to_cyc(ea + 6 * ST_A);
        ifa.start = 1'b0;
        to_cyc(ea + SWEEP_A + 2);

        // Asynchronous reset mid-cycle at idx=10, then a fresh full sweep.
        start_a(MODE_LUT, ea);
        to_cyc(ea + 10 * ST_A + 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_drive", {27'd0, ifa.A, ifa.S0, ifa.S1, ifa.M}, 32'd0);
        check("arst_busy", {31'd0, ifa.busy}, 32'd0);
        check("arst_valid", {31'd0, ifa.table_valid}, 32'd0);
        check("arst_table", ifa.truth_table, 32'd0);
        sb.delete();
        to_cyc(cyc + 2);
        rst_n = 1'b1;
        @(negedge clk);
        start_a(MODE_LUT, ea);
        to_cyc(ea + SWEEP_A + 2);

        // Randomized tables with random consumer stall.
        for (int r = 0; r < 3; r++) begin
            ifa.out_ready = 1'b0;
            start_a(MODE_LUT, ea);
            d = $urandom_range(0, 5);
            to_cyc(ea + SWEEP_A + d);
            ifa.out_ready = 1'b1;
            to_cyc(ea + SWEEP_A + d + 2);
        end

        // Back-to-back: start held high, result=A[1].
        mode = MODE_A1;
        ifa.out_ready = 1'b1;
        ifa.start = 1'b1;
        e1 = cyc + 1;
        sb.push_back('{tbl: exp_table(MODE_A1, lut), start_cyc: e1});
        sb.push_back('{tbl: exp_table(MODE_A1, lut), start_cyc: e1 + SWEEP_A + 2});
        to_cyc(e1 + 2 * SWEEP_A + 1);
        ifa.start = 1'b0;
        to_cyc(e1 + 2 * SWEEP_A + 6);
        check("b2b_stopped", {31'd0, ifa.busy}, 32'd0);
        check("b2b_sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
